true_dual_port_mem_bank: RTL and testbench
==========================================

TRUE_DUAL_PORT_MEM_BANK -- requirements
Module: true_dual_port_mem_bank

Interface
REQ-001 SHALL have parameter collection, default 2: number of collections.
REQ-002 SHALL have parameter z, default 2: memories per collection.
REQ-003 SHALL have parameter depth, default 2: cells per memory; addrsize = 1 if depth==1, else clog2(depth).
REQ-004 SHALL have parameter width, default 4: bits per cell.
REQ-005 SHALL have parameter read_mode, default 0: 0 = read-first, 1 = write-first (same-port only).
REQ-006 SHALL have parameter out_reg, default 0: 1 adds an output pipeline register.
REQ-007 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port addressA / addressB  input  [collection][z] x addrsize  per-memory port address.
REQ-010 SHALL have port weA / weB  input  [collection] x z  per-memory write enable.
REQ-011 SHALL have port data_inA / data_inB  input  [collection][z] x width  write data.
REQ-012 SHALL have port data_outA / data_outB  output  [collection][z] x width  read data.
REQ-013 SHALL have port busy  output  1  high while reset or the clear sweep is active.
REQ-014 SHALL have port collision  output  [collection] x z  one-cycle pulse marking a dual-write address collision.

Function
REQ-015 SHALL have states CLEAR and READY; reset forces CLEAR with the sweep pointer at 0.
REQ-016 In CLEAR, SHALL write 0 to cell[ptr] of every memory, one address per cycle, ptr 0..depth-1, then enter READY; busy=1 throughout CLEAR.
REQ-017 SHALL clear in exactly depth cycles after reset deassertion, then drive busy=0.
REQ-018 While busy, SHALL ignore weA/weB, hold data_out* at 0 and hold collision at 0.
REQ-019 In READY, every port SHALL read every cycle; read latency 1 cycle (out_reg=0) or 2 cycles (out_reg=1).
REQ-020 Same-port write with read_mode=0 SHALL return old cell contents; with read_mode=1 it SHALL return data_in.
REQ-021 A cross-port read of an address being written in the same cycle SHALL return the old contents, in both modes.
REQ-022 When both ports write the same address of one memory in one cycle, port A data SHALL be stored, and collision for that memory SHALL be 1 on the following cycle only.
REQ-023 Writes to different addresses, or to different memories, SHALL all complete independently in the same cycle.
REQ-024 An address >= depth SHALL suppress the write and return 0 on read.
REQ-025 Memories SHALL be fully independent; weX[i][j] affects only memory (i,j).

Reset
REQ-026 On reset, data_outA, data_outB, collision and the out_reg pipeline SHALL be 0, and busy SHALL be 1.
REQ-027 Reset asserted mid-CLEAR or mid-READY SHALL restart the sweep at 0; contents are guaranteed zero only after busy falls.

Configuration
REQ-028 With macro TDPM_COLLISION_CNT_EN defined, SHALL add output collision_count (16 bits): total collision events across all memories in a cycle, added per cycle, saturating at 16'hFFFF, cleared by reset.
REQ-029 Without TDPM_COLLISION_CNT_EN, port collision_count and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
Defaults apply unless stated: collection=2, z=2, depth=2, width=4.
REQ-030 Reset 1 cycle, then release -> busy=1 for 2 cycles then 0; all outputs 0; reading every cell returns 0.
REQ-031 read_mode=0: A writes i+j+1 to address 0 of all memories for two cycles -> data_outA shows 0, then 1,2,2,3.
REQ-032 read_mode=1, same stimulus as REQ-031 -> data_outA shows 1,2,2,3 in the first write cycle.
REQ-033 Memory c1m1: A writes 4'hA and B writes 4'h5 to address 1 in the same cycle -> collision[1][1]=1 for one cycle; next read gives 4'hA; collision_count=1 when the macro is defined.
REQ-034 out_reg=1: write 4'h9 to address 1, then read it -> data appears 2 cycles after the read address is presented.
REQ-035 Write cells to 4'hF, assert reset in the first READY cycle -> busy reasserts, sweep restarts at 0, and all cells read 0 afterward.

Source files
------------

// File: rtl/true_dual_port_mem_bank.sv
// Banked true dual-port RAM (collection x z memories), zeroed by a one-address-per-cycle sweep after reset.
// Read latency 1 cycle (2 with out_reg); no backpressure, busy flags the sweep; TDPM_COLLISION_CNT_EN adds collision_count.
module true_dual_port_mem_bank #(
  parameter int collection = 2,
  parameter int z = 2,
  parameter int depth = 2,
  parameter int width = 4,
  parameter int read_mode = 0,
  parameter int out_reg = 0,
  localparam int addrsize = (depth == 1) ? 1 : $clog2(depth)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [collection-1:0][z-1:0][addrsize-1:0]  addressA,
  input  logic [collection-1:0][z-1:0][addrsize-1:0]  addressB,
  input  logic [collection-1:0][z-1:0]                weA,
  input  logic [collection-1:0][z-1:0]                weB,
  input  logic [collection-1:0][z-1:0][width-1:0]     data_inA,
  input  logic [collection-1:0][z-1:0][width-1:0]     data_inB,
  output logic [collection-1:0][z-1:0][width-1:0]     data_outA,
  output logic [collection-1:0][z-1:0][width-1:0]     data_outB,
  output logic                                        busy,
  output logic [collection-1:0][z-1:0]                collision
`ifdef TDPM_COLLISION_CNT_EN
  ,
  output logic [15:0]                                 collision_count
`endif
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} stateT;

  localparam logic [addrsize-1:0] lastPtr    = addrsize'(depth - 1);
  localparam logic [addrsize:0]   depthLimit = (addrsize + 1)'(depth);

  stateT                                    state, stateNext;
  logic [addrsize-1:0]                      ptr, ptrNext;
  logic                                     sweeping, active;
  logic [width-1:0]                         mem [collection][z][depth];
  logic [collection-1:0][z-1:0]             validA, validB, writeA, writeB, hit;
  logic [collection-1:0][z-1:0][width-1:0]  readA, readB, stage1A, stage1B;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == lastPtr) begin
          stateNext = READY;
          ptrNext   = '0;
        end else begin
          ptrNext = ptr + 1'b1;
        end
      end
      READY:   stateNext = READY;
      default: stateNext = CLEAR;
    endcase
  end

  always_comb begin
    busy     = reset || (state == CLEAR);
    sweeping = (state == CLEAR);
    active   = (state == READY) && !reset;
  end

  // Out-of-range addresses neither write nor read; a dual write to one cell is a collision.
  always_comb begin
    validA = '0;
    validB = '0;
    writeA = '0;
    writeB = '0;
    hit    = '0;
    for (int i = 0; i < collection; i++) begin
      for (int j = 0; j < z; j++) begin
        validA[i][j] = {1'b0, addressA[i][j]} < depthLimit;
        validB[i][j] = {1'b0, addressB[i][j]} < depthLimit;
        writeA[i][j] = active && weA[i][j] && validA[i][j];
        writeB[i][j] = active && weB[i][j] && validB[i][j];
        hit[i][j]    = writeA[i][j] && writeB[i][j] && (addressA[i][j] == addressB[i][j]);
      end
    end
  end

  // Port A is applied last so it wins a same-address dual write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < collection; i++) begin
      for (int j = 0; j < z; j++) begin
        if (sweeping) begin
          mem[i][j][ptr] <= '0;
        end else begin
          if (writeB[i][j]) mem[i][j][addressB[i][j]] <= data_inB[i][j];
          if (writeA[i][j]) mem[i][j][addressA[i][j]] <= data_inA[i][j];
        end
      end
    end
  end

  always_comb begin
    readA = '0;
    readB = '0;
    for (int i = 0; i < collection; i++) begin
      for (int j = 0; j < z; j++) begin
        if (active && validA[i][j]) begin
          if (read_mode == 1 && writeA[i][j]) readA[i][j] = data_inA[i][j];
          else                                readA[i][j] = mem[i][j][addressA[i][j]];
        end
        if (active && validB[i][j]) begin
          if (read_mode == 1 && writeB[i][j]) readB[i][j] = data_inB[i][j];
          else                                readB[i][j] = mem[i][j][addressB[i][j]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1A   <= '0;
      stage1B   <= '0;
      collision <= '0;
    end else begin
      stage1A   <= readA;
      stage1B   <= readB;
      collision <= hit;
    end
  end

  generate
    if (out_reg != 0) begin : gOutReg
      logic [collection-1:0][z-1:0][width-1:0] stage2A, stage2B;
      always_ff @(posedge clk) begin
        if (!active) begin
          stage2A <= '0;
          stage2B <= '0;
        end else begin
          stage2A <= stage1A;
          stage2B <= stage1B;
        end
      end
      assign data_outA = stage2A;
      assign data_outB = stage2B;
    end else begin : gNoOutReg
      assign data_outA = stage1A;
      assign data_outB = stage1B;
    end
  endgenerate

`ifdef TDPM_COLLISION_CNT_EN
  logic [16:0] hitSum, countSum;

  always_comb begin
    hitSum = '0;
    for (int i = 0; i < collection; i++) begin
      for (int j = 0; j < z; j++) begin
        hitSum = hitSum + 17'(hit[i][j]);
      end
    end
    countSum = {1'b0, collision_count} + hitSum;
  end

  // Updates on the same edge as the collision pulse, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) collision_count <= '0;
    else       collision_count <= countSum[16] ? 16'hFFFF : countSum[15:0];
  end
`endif

endmodule

// File: tb/tb_true_dual_port_mem_bank.sv
// Bench for true_dual_port_mem_bank: four variants (read-first, write-first, out_reg, depth 3) on shared stimulus.
module tb_true_dual_port_mem_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [1:0][1:0][0:0]  addrA, addrB;
  logic [1:0][1:0][1:0]  addrA3, addrB3;
  logic [1:0][1:0]       weA, weB;
  logic [1:0][1:0][3:0]  dinA, dinB;

  logic [1:0][1:0][3:0]  rfOutA, rfOutB, wfOutA, wfOutB, orOutA, orOutB, d3OutA, d3OutB;
  logic                  rfBusy, wfBusy, orBusy, d3Busy;
  logic [1:0][1:0]       rfCol, wfCol, orCol, d3Col;
`ifdef TDPM_COLLISION_CNT_EN
  logic [15:0]           rfCnt, wfCnt, orCnt, d3Cnt;
`endif

  int checks = 0;
  int failures = 0;

  true_dual_port_mem_bank #(.read_mode(0), .out_reg(0)) dutRf (
    .clk(clk), .reset(reset), .addressA(addrA), .addressB(addrB), .weA(weA), .weB(weB),
    .data_inA(dinA), .data_inB(dinB), .data_outA(rfOutA), .data_outB(rfOutB),
    .busy(rfBusy), .collision(rfCol)
`ifdef TDPM_COLLISION_CNT_EN
    , .collision_count(rfCnt)
`endif
  );

  true_dual_port_mem_bank #(.read_mode(1), .out_reg(0)) dutWf (
    .clk(clk), .reset(reset), .addressA(addrA), .addressB(addrB), .weA(weA), .weB(weB),
    .data_inA(dinA), .data_inB(dinB), .data_outA(wfOutA), .data_outB(wfOutB),
    .busy(wfBusy), .collision(wfCol)
`ifdef TDPM_COLLISION_CNT_EN
    , .collision_count(wfCnt)
`endif
  );

  true_dual_port_mem_bank #(.read_mode(0), .out_reg(1)) dutOr (
    .clk(clk), .reset(reset), .addressA(addrA), .addressB(addrB), .weA(weA), .weB(weB),
    .data_inA(dinA), .data_inB(dinB), .data_outA(orOutA), .data_outB(orOutB),
    .busy(orBusy), .collision(orCol)
`ifdef TDPM_COLLISION_CNT_EN
    , .collision_count(orCnt)
`endif
  );

  true_dual_port_mem_bank #(.depth(3)) dutD3 (
    .clk(clk), .reset(reset), .addressA(addrA3), .addressB(addrB3), .weA(weA), .weB(weB),
    .data_inA(dinA), .data_inB(dinB), .data_outA(d3OutA), .data_outB(d3OutB),
    .busy(d3Busy), .collision(d3Col)
`ifdef TDPM_COLLISION_CNT_EN
    , .collision_count(d3Cnt)
`endif
  );

  // Reference model: k=0 is the depth-2 bank, k=1 the depth-3 bank.
  int         mDepth [2] = '{2, 3};
  logic [3:0] mMem [2][2][2][4];
  int         mBusyLeft [2];
  logic [3:0] eRfA [2][2][2];
  logic [3:0] eRfB [2][2][2];
  logic [3:0] eWfA [2][2];
  logic [3:0] eWfB [2][2];
  logic [3:0] eOrA [2][2];
  logic [3:0] eOrB [2][2];
  logic       eCol [2][2][2];
  int         mCount;

  task automatic modelStep(input int k);
    int aA, aB;
    bit vA, vB;
    if (reset || mBusyLeft[k] > 0) begin
      if (reset) mBusyLeft[k] = mDepth[k];
      else begin
        mBusyLeft[k]--;
        if (mBusyLeft[k] == 0)
          for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) for (int a = 0; a < 4; a++) mMem[k][i][j][a] = 4'h0;
      end
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        eRfA[k][i][j] = 4'h0; eRfB[k][i][j] = 4'h0; eCol[k][i][j] = 1'b0;
        if (k == 0) begin eWfA[i][j] = 4'h0; eWfB[i][j] = 4'h0; eOrA[i][j] = 4'h0; eOrB[i][j] = 4'h0; end
      end
      if (k == 0 && reset) mCount = 0;
      return;
    end
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
      if (k == 0) begin eOrA[i][j] = eRfA[0][i][j]; eOrB[i][j] = eRfB[0][i][j]; end
      aA = (k == 0) ? int'(addrA[i][j]) : int'(addrA3[i][j]);
      aB = (k == 0) ? int'(addrB[i][j]) : int'(addrB3[i][j]);
      vA = aA < mDepth[k];
      vB = aB < mDepth[k];
      eRfA[k][i][j] = vA ? mMem[k][i][j][aA] : 4'h0;
      eRfB[k][i][j] = vB ? mMem[k][i][j][aB] : 4'h0;
      if (k == 0) begin
        eWfA[i][j] = (weA[i][j] && vA) ? dinA[i][j] : eRfA[0][i][j];
        eWfB[i][j] = (weB[i][j] && vB) ? dinB[i][j] : eRfB[0][i][j];
      end
      eCol[k][i][j] = weA[i][j] && weB[i][j] && vA && vB && (aA == aB);
      if (k == 0 && eCol[k][i][j] && mCount < 65535) mCount++;
      if (weB[i][j] && vB) mMem[k][i][j][aB] = dinB[i][j];
      if (weA[i][j] && vA) mMem[k][i][j][aA] = dinA[i][j];
    end
  endtask

  task automatic tick();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    weA = '0;
    weB = '0;
  endtask

  task automatic test_reset();
    int n, m;
    reset = 1'b1; idle();
    addrA = '0; addrB = '0; addrA3 = '0; addrB3 = '0; dinA = '0; dinB = '0;
    tick();
    checks++; if (rfBusy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", rfBusy); end
    checks++; if (d3Busy !== 1'b1) begin failures++; $display("FAIL reset_busy_d3 got=%b exp=1", d3Busy); end
    checks++; if ({rfOutA, rfOutB} !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", {rfOutA, rfOutB}); end
    checks++; if ({orOutA, orOutB} !== 32'h0) begin failures++; $display("FAIL reset_outreg got=%h exp=0", {orOutA, orOutB}); end
    checks++; if (rfCol !== 4'h0) begin failures++; $display("FAIL reset_col got=%h exp=0", rfCol); end
    reset = 1'b0;
    n = 0;
    while (rfBusy === 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (n !== 2) begin failures++; $display("FAIL clear_cycles got=%0d exp=2", n); end
    m = n;
    while (d3Busy === 1'b1 && m < 20) begin m++; tick(); end
    checks++; if (m !== 3) begin failures++; $display("FAIL clear_cycles_d3 got=%0d exp=3", m); end
    for (int a = 0; a < 3; a++) begin
      addrA = {4{1'(a % 2)}}; addrB = addrA; addrA3 = {4{2'(a)}}; addrB3 = addrA3;
      tick();
      checks++; if ({rfOutA, rfOutB} !== 32'h0) begin failures++; $display("FAIL cleared_read a=%0d got=%h exp=0", a, {rfOutA, rfOutB}); end
      checks++; if ({d3OutA, d3OutB} !== 32'h0) begin failures++; $display("FAIL cleared_read_d3 a=%0d got=%h exp=0", a, {d3OutA, d3OutB}); end
    end
  endtask

  task automatic test_out_of_range();
    weA = '1; addrA = '1; addrB = '0; addrA3 = {4{2'd3}}; addrB3 = {4{2'd3}}; dinA = {4{4'h7}};
    tick();
    checks++; if ({d3OutA, d3OutB} !== 32'h0) begin failures++; $display("FAIL oor_read got=%h exp=0", {d3OutA, d3OutB}); end
    idle();
    for (int a = 0; a < 4; a++) begin
      addrA3 = {4{2'(a)}};
      tick();
      checks++; if (d3OutA !== 16'h0) begin failures++; $display("FAIL oor_suppressed a=%0d got=%h exp=0", a, d3OutA); end
    end
  endtask

  task automatic test_read_modes();
    weA = '1; addrA = '0; addrB = '0; addrA3 = '0; addrB3 = '0; dinA = 16'h3221;
    tick();
    checks++; if (rfOutA !== 16'h0000) begin failures++; $display("FAIL read_first got=%h exp=0000", rfOutA); end
    checks++; if (wfOutA !== 16'h3221) begin failures++; $display("FAIL write_first got=%h exp=3221", wfOutA); end
    checks++; if (wfOutB !== 16'h0000) begin failures++; $display("FAIL cross_port_old got=%h exp=0000", wfOutB); end
    tick();
    checks++; if (rfOutA !== 16'h3221) begin failures++; $display("FAIL read_first_2nd got=%h exp=3221", rfOutA); end
    checks++; if (rfOutB !== 16'h3221) begin failures++; $display("FAIL cross_port_2nd got=%h exp=3221", rfOutB); end
    idle();
  endtask

  task automatic test_collision();
    idle();
    weA = 4'b1000; weB = 4'b1000; addrA = '1; addrB = '1; addrA3 = {4{2'd1}}; addrB3 = {4{2'd1}};
    dinA = {4{4'hA}}; dinB = {4{4'h5}};
    tick();
    checks++; if (rfCol !== 4'b1000) begin failures++; $display("FAIL collision got=%b exp=1000", rfCol); end
    checks++; if (d3Col !== 4'b1000) begin failures++; $display("FAIL collision_d3 got=%b exp=1000", d3Col); end
    checks++; if (wfOutB[1][1] !== 4'h5) begin failures++; $display("FAIL coll_wf_b got=%h exp=5", wfOutB[1][1]); end
`ifdef TDPM_COLLISION_CNT_EN
    checks++; if (rfCnt !== 16'd1) begin failures++; $display("FAIL coll_count got=%0d exp=1", rfCnt); end
`endif
    idle();
    tick();
    checks++; if (rfCol !== 4'b0000) begin failures++; $display("FAIL collision_pulse got=%b exp=0000", rfCol); end
    checks++; if (rfOutA[1][1] !== 4'hA) begin failures++; $display("FAIL coll_winner got=%h exp=a", rfOutA[1][1]); end
    checks++; if (rfOutB[1][1] !== 4'hA) begin failures++; $display("FAIL coll_winner_b got=%h exp=a", rfOutB[1][1]); end
  endtask

  task automatic test_out_reg();
    weA = '1; addrA = '1; addrA3 = {4{2'd1}}; dinA = {4{4'h9}};
    tick();
    idle();
    tick();
    checks++; if (rfOutA !== 16'h9999) begin failures++; $display("FAIL outreg_base got=%h exp=9999", rfOutA); end
    checks++; if (orOutA !== 16'hA777) begin failures++; $display("FAIL outreg_lat1 got=%h exp=a777", orOutA); end
    tick();
    checks++; if (orOutA !== 16'h9999) begin failures++; $display("FAIL outreg_lat2 got=%h exp=9999", orOutA); end
  endtask

  task automatic test_reset_midway();
    int n;
    weA = '1; weB = '1; addrA = '0; addrB = '1; addrA3 = '0; addrB3 = {4{2'd1}};
    dinA = {4{4'hF}}; dinB = {4{4'hF}};
    tick();
    addrA3 = {4{2'd2}};
    tick();
    idle();
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (rfBusy === 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (n !== 2) begin failures++; $display("FAIL midway_clear1 got=%0d exp=2", n); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (rfBusy !== 1'b1) begin failures++; $display("FAIL midway_busy got=%b exp=1", rfBusy); end
    n = 0;
    while (rfBusy === 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (n !== 2) begin failures++; $display("FAIL midway_clear2 got=%0d exp=2", n); end
    n = 0;
    while (d3Busy === 1'b1 && n < 20) begin n++; tick(); end
    for (int a = 0; a < 3; a++) begin
      addrA = {4{1'(a % 2)}}; addrB = addrA; addrA3 = {4{2'(a)}}; addrB3 = addrA3;
      tick();
      checks++; if ({rfOutA, rfOutB} !== 32'h0) begin failures++; $display("FAIL midway_read a=%0d got=%h exp=0", a, {rfOutA, rfOutB}); end
      checks++; if ({d3OutA, d3OutB} !== 32'h0) begin failures++; $display("FAIL midway_read_d3 a=%0d got=%h exp=0", a, {d3OutA, d3OutB}); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset  = ($urandom_range(0, 99) == 0);
      weA    = 4'($urandom);  weB    = 4'($urandom);
      addrA  = 4'($urandom);  addrB  = 4'($urandom);
      addrA3 = 8'($urandom);  addrB3 = 8'($urandom);
      dinA   = 16'($urandom); dinB   = 16'($urandom);
      tick();
      checks++; if (rfBusy !== (reset || mBusyLeft[0] > 0)) begin failures++; $display("FAIL rand_busy c=%0d got=%b", c, rfBusy); end
      checks++; if (orBusy !== (reset || mBusyLeft[0] > 0)) begin failures++; $display("FAIL rand_busy_or c=%0d got=%b", c, orBusy); end
      checks++; if (d3Busy !== (reset || mBusyLeft[1] > 0)) begin failures++; $display("FAIL rand_busy_d3 c=%0d got=%b", c, d3Busy); end
`ifdef TDPM_COLLISION_CNT_EN
      checks++; if (rfCnt !== 16'(mCount)) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, rfCnt, mCount); end
`endif
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        checks++; if (rfOutA[i][j] !== eRfA[0][i][j]) begin failures++; $display("FAIL rand_rfA[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, rfOutA[i][j], eRfA[0][i][j]); end
        checks++; if (rfOutB[i][j] !== eRfB[0][i][j]) begin failures++; $display("FAIL rand_rfB[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, rfOutB[i][j], eRfB[0][i][j]); end
        checks++; if (wfOutA[i][j] !== eWfA[i][j]) begin failures++; $display("FAIL rand_wfA[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, wfOutA[i][j], eWfA[i][j]); end
        checks++; if (wfOutB[i][j] !== eWfB[i][j]) begin failures++; $display("FAIL rand_wfB[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, wfOutB[i][j], eWfB[i][j]); end
        checks++; if (orOutA[i][j] !== eOrA[i][j]) begin failures++; $display("FAIL rand_orA[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, orOutA[i][j], eOrA[i][j]); end
        checks++; if (orOutB[i][j] !== eOrB[i][j]) begin failures++; $display("FAIL rand_orB[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, orOutB[i][j], eOrB[i][j]); end
        checks++; if (d3OutA[i][j] !== eRfA[1][i][j]) begin failures++; $display("FAIL rand_d3A[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, d3OutA[i][j], eRfA[1][i][j]); end
        checks++; if (d3OutB[i][j] !== eRfB[1][i][j]) begin failures++; $display("FAIL rand_d3B[%0d][%0d] c=%0d got=%h exp=%h", i, j, c, d3OutB[i][j], eRfB[1][i][j]); end
        checks++; if (rfCol[i][j] !== eCol[0][i][j]) begin failures++; $display("FAIL rand_col[%0d][%0d] c=%0d got=%b exp=%b", i, j, c, rfCol[i][j], eCol[0][i][j]); end
        checks++; if (wfCol[i][j] !== eCol[0][i][j]) begin failures++; $display("FAIL rand_col_wf[%0d][%0d] c=%0d got=%b exp=%b", i, j, c, wfCol[i][j], eCol[0][i][j]); end
        checks++; if (orCol[i][j] !== eCol[0][i][j]) begin failures++; $display("FAIL rand_col_or[%0d][%0d] c=%0d got=%b exp=%b", i, j, c, orCol[i][j], eCol[0][i][j]); end
        checks++; if (d3Col[i][j] !== eCol[1][i][j]) begin failures++; $display("FAIL rand_col_d3[%0d][%0d] c=%0d got=%b exp=%b", i, j, c, d3Col[i][j], eCol[1][i][j]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mBusyLeft[0] = 0;
    mBusyLeft[1] = 0;
    mCount = 0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
      eRfA[k][i][j] = 4'h0; eRfB[k][i][j] = 4'h0; eCol[k][i][j] = 1'b0;
      for (int a = 0; a < 4; a++) mMem[k][i][j][a] = 4'h0;
    end
    test_reset();
    test_out_of_range();
    test_read_modes();
    test_collision();
    test_out_reg();
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
